// File: rtl/bht_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters: combinational
// lookup on the fetch PC, registered update from the EX resolution port, two event counters.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module bht_predictor #(
    parameter int PC_BIT  = `IM_ADDR_BIT,
    parameter int IDX_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [PC_BIT-1:0] pc,
    input  logic [PC_BIT-1:0] pc_4,
    output logic [PC_BIT-1:0] pc_guessed,
    output logic [1:0]        bht_state,
    output logic              hit,
    input  logic              upd_valid,
    input  logic [PC_BIT-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [PC_BIT-1:0] upd_target,
    input  logic [1:0]        upd_bht_state,
    input  logic              upd_mispredict,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int ENTRIES = 2 ** IDX_BIT;
    localparam int TAG_BIT = PC_BIT - IDX_BIT;

    // Flattened views of the per-entry registers, read by lookup and update logic
    logic               valid_vec  [ENTRIES];
    logic [TAG_BIT-1:0] tag_vec    [ENTRIES];
    logic [PC_BIT-1:0]  target_vec [ENTRIES];
    logic [1:0]         state_vec  [ENTRIES];

    logic [IDX_BIT-1:0] look_idx;
    logic [TAG_BIT-1:0] look_tag;
    logic [IDX_BIT-1:0] upd_idx;
    logic [TAG_BIT-1:0] upd_tag;
    logic               upd_hit;
    logic [1:0]         state_next;
    logic               upd_write;

    logic [31:0] branches_reg;
    logic [31:0] mispred_reg;

    assign look_idx = pc[IDX_BIT-1:0];
    assign look_tag = pc[PC_BIT-1:IDX_BIT];
    assign upd_idx  = upd_pc[IDX_BIT-1:0];
    assign upd_tag  = upd_pc[PC_BIT-1:IDX_BIT];

    // Lookup sees only registered table contents, so an update lands one cycle later
    always_comb begin
        hit        = valid_vec[look_idx] && (tag_vec[look_idx] == look_tag);
        bht_state  = 2'b01;
        pc_guessed = pc_4;
        if (hit) begin
            bht_state = state_vec[look_idx];
            if (state_vec[look_idx][1]) begin
                pc_guessed = target_vec[look_idx];
            end
        end
    end

    // Next counter derives from the state that travelled with the instruction
    always_comb begin
        state_next = upd_bht_state;
        if (upd_taken) begin
            if (upd_bht_state != 2'b11) begin
                state_next = upd_bht_state + 2'b01;
            end
        end else begin
            if (upd_bht_state != 2'b00) begin
                state_next = upd_bht_state - 2'b01;
            end
        end
    end

    assign upd_hit   = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
    assign upd_write = upd_valid && !flush;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic               valid_reg;
            logic [TAG_BIT-1:0] tag_reg;
            logic [PC_BIT-1:0]  target_reg;
            logic [1:0]         state_reg;
            logic               entry_sel;

            assign entry_sel = upd_write && (upd_idx == IDX_BIT'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    state_reg  <= 2'b00;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (entry_sel) begin
                    if (upd_hit) begin
                        state_reg <= state_next;
                        if (upd_taken) begin
                            target_reg <= upd_target;
                        end
                    end else if (upd_taken) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= upd_target;
                        state_reg  <= 2'b10;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
            assign state_vec[gi]  = state_reg;
        end
    endgenerate

    // Statistics keep counting through flushes; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_reg <= '0;
            mispred_reg  <= '0;
        end else if (upd_valid) begin
            branches_reg <= branches_reg + 32'd1;
            if (upd_mispredict) begin
                mispred_reg <= mispred_reg + 32'd1;
            end
        end
    end

    assign stat_branches = branches_reg;
    assign stat_mispred  = mispred_reg;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: hand-computed lookups, counter saturation,
// aliasing, flush priority, statistics and asynchronous reset.
module tb_bht_predictor;

    localparam int PC_BIT  = 10;
    localparam int IDX_BIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [PC_BIT-1:0] pc;
    logic [PC_BIT-1:0] pc_4;
    logic [PC_BIT-1:0] pc_guessed;
    logic [1:0]        bht_state;
    logic              hit;
    logic              upd_valid;
    logic [PC_BIT-1:0] upd_pc;
    logic              upd_taken;
    logic [PC_BIT-1:0] upd_target;
    logic [1:0]        upd_bht_state;
    logic              upd_mispredict;
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispred;

    int checks   = 0;
    int failures = 0;

    bht_predictor #(.PC_BIT(PC_BIT), .IDX_BIT(IDX_BIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .pc             (pc),
        .pc_4           (pc_4),
        .pc_guessed     (pc_guessed),
        .bht_state      (bht_state),
        .hit            (hit),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_bht_state  (upd_bht_state),
        .upd_mispredict (upd_mispredict),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // Drives one resolved branch at a negedge; returns at the following negedge
    task automatic upd(input logic [PC_BIT-1:0] p, input logic t, input logic [PC_BIT-1:0] tg,
                       input logic [1:0] s, input logic m);
        upd_valid      = 1'b1;
        upd_pc         = p;
        upd_taken      = t;
        upd_target     = tg;
        upd_bht_state  = s;
        upd_mispredict = m;
        @(posedge clk);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        @(negedge clk);
    endtask

    task automatic look(input logic [PC_BIT-1:0] p, input logic [PC_BIT-1:0] p4,
                        input logic eh, input logic [1:0] es, input logic [PC_BIT-1:0] eg,
                        input string name);
        pc   = p;
        pc_4 = p4;
        #1;
        chk({name, "_hit"}, 32'(hit), 32'(eh));
        chk({name, "_state"}, 32'(bht_state), 32'(es));
        chk({name, "_guess"}, 32'(pc_guessed), 32'(eg));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; pc = 10'h010; pc_4 = 10'h011;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_bht_state = 2'b00; upd_mispredict = 1'b0;

        // Reset state
        #12;
        look(10'h010, 10'h011, 1'b0, 2'b01, 10'h011, "reset");
        chk("reset_branches", stat_branches, 32'd0);
        chk("reset_mispred", stat_mispred, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Allocation; same-cycle lookup still sees the old (empty) entry
        upd_valid = 1'b1; upd_pc = 10'h010; upd_taken = 1'b1; upd_target = 10'h040;
        upd_bht_state = 2'b01; upd_mispredict = 1'b0;
        #1;
        chk("no_bypass_hit", 32'(hit), 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        look(10'h010, 10'h011, 1'b1, 2'b10, 10'h040, "alloc");
        chk("branches_1", stat_branches, 32'd1);

        // Saturation high then low, using the carried state
        for (int i = 0; i < 4; i++) upd(10'h010, 1'b1, 10'h040, 2'b11, 1'b0);
        look(10'h010, 10'h011, 1'b1, 2'b11, 10'h040, "sat_hi");
        for (int i = 0; i < 4; i++) upd(10'h010, 1'b0, 10'h3FF, 2'b00, 1'b0);
        look(10'h010, 10'h011, 1'b1, 2'b00, 10'h011, "sat_lo");
        upd(10'h010, 1'b0, 10'h3FF, 2'b10, 1'b0);
        look(10'h010, 10'h011, 1'b1, 2'b01, 10'h011, "weak_nt");
        upd(10'h010, 1'b1, 10'h055, 2'b01, 1'b0);
        look(10'h010, 10'h011, 1'b1, 2'b10, 10'h055, "retarget");
        chk("branches_11", stat_branches, 32'd11);

        // Aliasing on idx 0 and a not-taken miss that must not write
        upd(10'h020, 1'b1, 10'h077, 2'b01, 1'b0);
        look(10'h010, 10'h011, 1'b0, 2'b01, 10'h011, "alias_old");
        look(10'h020, 10'h021, 1'b1, 2'b10, 10'h077, "alias_new");
        upd(10'h030, 1'b0, 10'h111, 2'b11, 1'b0);
        look(10'h020, 10'h021, 1'b1, 2'b10, 10'h077, "nt_miss_keep");
        look(10'h030, 10'h031, 1'b0, 2'b01, 10'h031, "nt_miss_none");
        upd(10'h013, 1'b1, 10'h100, 2'b00, 1'b0);
        look(10'h013, 10'h014, 1'b1, 2'b10, 10'h100, "alloc_idx3");

        // Flush beats a same-cycle taken update; counting continues
        flush = 1'b1;
        upd(10'h025, 1'b1, 10'h0AA, 2'b01, 1'b0);
        flush = 1'b0;
        look(10'h020, 10'h021, 1'b0, 2'b01, 10'h021, "flush_0x020");
        look(10'h013, 10'h014, 1'b0, 2'b01, 10'h014, "flush_0x013");
        look(10'h025, 10'h026, 1'b0, 2'b01, 10'h026, "flush_0x025");
        chk("branches_15", stat_branches, 32'd15);
        chk("mispred_0", stat_mispred, 32'd0);

        // Fresh reset, then 5 updates with 2 mispredicts
        rst_n = 1'b0;
        #1;
        chk("rst1_branches", stat_branches, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        upd(10'h018, 1'b1, 10'h0C0, 2'b01, 1'b1);
        upd(10'h018, 1'b1, 10'h0C0, 2'b10, 1'b0);
        upd(10'h019, 1'b0, 10'h000, 2'b01, 1'b0);
        upd(10'h018, 1'b0, 10'h000, 2'b11, 1'b1);
        upd(10'h01A, 1'b1, 10'h0D0, 2'b00, 1'b0);
        upd_mispredict = 1'b1;
        @(posedge clk);
        #1;
        upd_mispredict = 1'b0;
        @(negedge clk);
        chk("stat_branches_5", stat_branches, 32'd5);
        chk("stat_mispred_2", stat_mispred, 32'd2);
        look(10'h018, 10'h019, 1'b1, 2'b10, 10'h0C0, "pre_rst");
        look(10'h01A, 10'h01B, 1'b1, 2'b10, 10'h0D0, "pre_rst_a");

        // Asynchronous reset between edges takes effect immediately
        pc = 10'h018; pc_4 = 10'h019;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_branches", stat_branches, 32'd0);
        chk("async_mispred", stat_mispred, 32'd0);
        chk("async_hit", 32'(hit), 32'd0);
        chk("async_guess", 32'(pc_guessed), 32'h019);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
